inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit between the program counter register and the decode stage. It issues the current PC to instruction memory over a request/grant port and accepts in-order read responses with variable latency. Fetched words are paired with their PC in a small buffer and presented to decode with a valid/ready handshake. It tells the PC register when to advance, and flushes wrong-path work when a branch redirect (PCsrc) occurs.

## Interface
- DEPTH, 4: instruction buffer entries, which is also the maximum number of in-flight requests; power of 2, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- PC  in  32  current program counter from the PC register
- PCsrc  in  1  branch redirect; PC loads the branch target at the next edge
- PCen  out  1  PC register advances at this edge
- MemReq  out  1  fetch request valid
- MemAddr  out  32  word-aligned fetch address
- MemGnt  in  1  memory accepts the request this cycle
- MemRvalid  in  1  read response valid; responses arrive in request order
- MemRdata  in  32  instruction word
- InstrValid  out  1  Instr/InstrPC valid to decode
- Instr  out  32  instruction at buffer head
- InstrPC  out  32  PC of Instr
- InstrReady  in  1  decode consumes the head entry

## Operation
- State:
  - Instruction buffer: DEPTH entries of {PC, word}, circular, with count.
  - In-flight PC queue: DEPTH entries, with inflight count.
  - Discard counter.
- Credit rule: a request may be issued only if count + inflight < DEPTH. Discarded in-flight requests still hold credit until their response returns, so the buffer can never overflow.
- MemReq = credit available & ~PCsrc. MemAddr = {PC[31:2], 2'b00}; PC[1:0] is ignored.
- Request accept: on MemReq & MemGnt, push PC onto the in-flight queue.
- PCen = (MemReq & MemGnt) | PCsrc. The PC holds while the request is not accepted.
- Response handling: on MemRvalid, pop the in-flight queue.
  - If discard > 0, or PCsrc = 1 this cycle: drop the word and decrement discard if it is nonzero.
  - Otherwise push {popped PC, MemRdata} into the buffer.
- Decode handshake: InstrValid = count ≠ 0. The head is popped on InstrValid & InstrReady. Instr and InstrPC stay stable while InstrValid & ~InstrReady.
- Flush (PCsrc = 1):
  - Buffer count cleared; any pop that cycle has no extra effect.
  - discard ← inflight remaining after this cycle's response retirement.
  - No request issued.
- A new request may issue in the cycle after a flush even while discards are pending. New responses follow the discarded ones in order.
- MemRvalid with inflight = 0 is a protocol violation and is ignored; no state changes.
- Simultaneous events in one cycle are legal: push, pop, request and response. Count and inflight update with the net ±1.

## Timing
- Reset values: all outputs 0 (PCen, MemReq, MemAddr, InstrValid, Instr, InstrPC). All counts and pointers 0.
  - After rst deasserts, MemReq follows its combinational rule on the first cycle.
  - Reset mid-operation drops every in-flight request and buffered entry.
  - Responses already in flight at memory must be cancelled by the memory's own reset.
- MemReq, MemAddr and PCen are combinational from state, PC and PCsrc. InstrValid, Instr and InstrPC are registered, driven from buffer state.
- Latency:
  - Grant at cycle N.
  - Earliest MemRvalid at N+1; a response in the grant cycle is not allowed.
  - InstrValid at N+2 at the earliest.
- Throughput: with 1-cycle memory latency, InstrReady = 1 and DEPTH = 4, one instruction per cycle in steady state.
- Wrap-around: buffer and in-flight pointers wrap modulo DEPTH, with no bubble.

## Test plan
- Reset, then stream with MemGnt = 1, 1-cycle latency, InstrReady = 1, PC from 0x0 stepping by 4: the first InstrValid comes 2 cycles after the first grant. Instr/InstrPC pairs are 0x0, 0x4, 0x8, … with no gaps after warm-up.
- InstrReady = 0 for 10 cycles: MemReq drops after 4 requests in total (count + inflight = 4) and PCen = 0. Instr holds at the first entry. Releasing InstrReady resumes fetch in order.
- Variable latency (responses 1–5 cycles late, MemGnt toggled randomly): InstrPC values stay strictly sequential, with no loss or duplication.
- PCsrc asserted with 3 requests in flight, PC → 0x100 next cycle: the next 3 responses are dropped. The first InstrValid afterwards has InstrPC = 0x100. PCen = 1 in the flush cycle.
- PCsrc in the same cycle as MemRvalid and InstrReady: that response is dropped and the buffer is empty next cycle. The discard count equals the remaining in-flight count.
- rst asserted mid-stream with the buffer full: all outputs are 0 immediately (asynchronously). Fetch restarts cleanly from the PC present after reset.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues PC requests to instruction memory under a credit
// limit, pairs in-order responses with their PC and hands them to decode.
module inst_fetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        PCsrc,
  output logic        PCen,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemGnt,
  input  logic        MemRvalid,
  input  logic [31:0] MemRdata,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  input  logic        InstrReady
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   entry_pc   [DEPTH];
  logic [31:0]   entry_word [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [31:0]   fly_pc [DEPTH];
  logic [PW-1:0] fly_rd;
  logic [PW-1:0] fly_wr;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;

  logic [CW:0]   occupancy;
  logic          credit;
  logic          req_fire;
  logic          rsp;
  logic          drop;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_next;
  logic [CW-1:0] inflight_next;

  // Discarded requests keep their credit until the response returns, so
  // buffer plus in-flight can never exceed DEPTH.
  always_comb begin
    occupancy = {1'b0, count} + {1'b0, inflight};
    credit    = occupancy < (CW+1)'(DEPTH);
    MemReq    = ~rst & credit & ~PCsrc;
    req_fire  = MemReq & MemGnt;
    PCen      = ~rst & (req_fire | PCsrc);
    MemAddr   = rst ? 32'h0 : {PC[31:2], 2'b00};
  end

  always_comb begin
    rsp        = MemRvalid & (inflight != '0);
    drop       = (discard != '0) | PCsrc;
    push       = rsp & ~drop;
    InstrValid = count != '0;
    pop        = InstrValid & InstrReady & ~PCsrc;
    Instr      = InstrValid ? entry_word[head] : 32'h0;
    InstrPC    = InstrValid ? entry_pc[head]   : 32'h0;
  end

  always_comb begin
    count_next = count;
    if (push & ~pop)
      count_next = count + CW'(1);
    else if (~push & pop)
      count_next = count - CW'(1);

    inflight_next = inflight;
    if (req_fire & ~rsp)
      inflight_next = inflight + CW'(1);
    else if (~req_fire & rsp)
      inflight_next = inflight - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fly_rd   <= '0;
      fly_wr   <= '0;
      inflight <= '0;
      discard  <= '0;
    end else begin
      if (req_fire)
        fly_wr <= fly_wr + PW'(1);
      if (rsp)
        fly_rd <= fly_rd + PW'(1);
      inflight <= inflight_next;

      // A flush empties the buffer and marks every still-outstanding request
      // as wrong-path, including ones already marked earlier.
      if (PCsrc) begin
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        discard <= inflight_next;
      end else begin
        if (push)
          tail <= tail + PW'(1);
        if (pop)
          head <= head + PW'(1);
        count <= count_next;
        if (rsp && (discard != '0))
          discard <= discard - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire)
      fly_pc[fly_wr] <= PC;
    if (push) begin
      entry_pc[tail]   <= fly_pc[fly_rd];
      entry_word[tail] <= MemRdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a queue-based memory and decode model checked every
// cycle, plus directed literal expectations for latency, stall, flush and reset.
module tb_inst_fetch;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] PC;
  logic        PCsrc;
  logic        PCen;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemGnt;
  logic        MemRvalid;
  logic [31:0] MemRdata;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrReady;

  inst_fetch #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .PC         (PC),
    .PCsrc      (PCsrc),
    .PCen       (PCen),
    .MemReq     (MemReq),
    .MemAddr    (MemAddr),
    .MemGnt     (MemGnt),
    .MemRvalid  (MemRvalid),
    .MemRdata   (MemRdata),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .InstrPC    (InstrPC),
    .InstrReady (InstrReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } req_t;

  req_t        mem_q[$];
  logic [31:0] mbuf[$];
  int          epoch = 0;
  int          cycle = 0;
  int          phase = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  bit          bogus = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic [31:0] target = 32'h0;
  logic [31:0] pin_pc = 32'h0;
  logic [31:0] next_seq = 32'h0;
  int          passed = 0;
  int          total = 0;

  bit await_first = 1'b0;
  bit await_reset_kind = 1'b0;
  bit flush_prev = 1'b0;
  int first_grant = -1;
  int stall_grants = 0;
  int p1_consumes = 0;
  int last_phase = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5C3_0F96;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
  endtask

  // Model state after each edge is compared at the following negedge; the
  // model then absorbs this cycle's events ready for the next edge.
  always @(negedge clk) begin
    req_t e;
    bit   exp_valid;
    bit   exp_req;
    bit   rsp_ok;

    rsp_ok = 1'b0;
    if (phase != last_phase) begin
      if (last_phase == 1)
        check_output("stream_consumes", 32'(p1_consumes), 32'd28);
      if (last_phase == 2)
        check_output("stall_grants", 32'(stall_grants), 32'd4);
      last_phase = phase;
    end

    if (rst) begin
      check_output("rst_PCen", 32'(PCen), 32'h0);
      check_output("rst_MemReq", 32'(MemReq), 32'h0);
      check_output("rst_MemAddr", MemAddr, 32'h0);
      check_output("rst_InstrValid", 32'(InstrValid), 32'h0);
      check_output("rst_Instr", Instr, 32'h0);
      check_output("rst_InstrPC", InstrPC, 32'h0);
      mbuf.delete();
      mem_q.delete();
      await_first = 1'b1;
      await_reset_kind = 1'b1;
      first_grant = -1;
      flush_prev = 1'b0;
      next_seq = pin_pc;
      pc_next = PC;
    end else begin
      exp_valid = mbuf.size() != 0;
      exp_req = (mbuf.size() + mem_q.size() < DEPTH) && !PCsrc;
      check_output("InstrValid", 32'(InstrValid), 32'(exp_valid));
      if (exp_valid) begin
        check_output("InstrPC", InstrPC, mbuf[0]);
        check_output("Instr", Instr, word_of(mbuf[0]));
      end
      check_output("MemReq", 32'(MemReq), 32'(exp_req));
      check_output("MemAddr", MemAddr, {PC[31:2], 2'b00});
      check_output("PCen", 32'(PCen), 32'((exp_req && MemGnt) || PCsrc));

      if (flush_prev)
        check_output("flush_empties_buffer", 32'(InstrValid), 32'h0);
      flush_prev = PCsrc;
      if (PCsrc) begin
        check_output("flush_PCen", 32'(PCen), 32'h1);
        check_output("flush_no_req", 32'(MemReq), 32'h0);
      end

      if (phase == 2) begin
        if (stall_grants == 4) begin
          check_output("stall_MemReq", 32'(MemReq), 32'h0);
          check_output("stall_PCen", 32'(PCen), 32'h0);
        end
        if (InstrValid)
          check_output("stall_hold_pc", InstrPC, 32'h0);
        if (MemReq && MemGnt)
          stall_grants++;
      end

      if (await_first && await_reset_kind && first_grant < 0 && MemReq && MemGnt)
        first_grant = cycle;
      if (await_first && InstrValid) begin
        check_output("first_InstrPC", InstrPC, pin_pc);
        if (await_reset_kind)
          check_output("grant_to_valid", 32'(cycle - first_grant), 32'd2);
        await_first = 1'b0;
      end

      if (InstrValid && InstrReady && !PCsrc) begin
        if (phase == 1)
          p1_consumes++;
        check_output("decode_order", InstrPC, next_seq);
        next_seq = next_seq + 32'd4;
      end

      if (MemRvalid && mem_q.size() > 0) begin
        e = mem_q.pop_front();
        rsp_ok = (e.ep == epoch) && !PCsrc;
      end
      if (exp_valid && InstrReady && !PCsrc)
        void'(mbuf.pop_front());
      if (rsp_ok)
        mbuf.push_back(e.addr);
      if (exp_req && MemGnt)
        mem_q.push_back('{addr: PC, due: cycle + int'($urandom_range(lat_hi, lat_lo)), ep: epoch});
      if (PCsrc) begin
        mbuf.delete();
        epoch++;
        await_first = 1'b1;
        await_reset_kind = 1'b0;
        next_seq = pin_pc;
      end
      pc_next = PCsrc ? target : (PCen ? PC + 32'd4 : PC);
    end
  end

  // The bench acts as PC register and in-order memory, driving just after each edge.
  task automatic apply_stimulus(input bit r, input bit g, input bit rdy, input bit src,
                                input logic [31:0] tgt);
    @(posedge clk);
    #1;
    cycle++;
    PC = pc_next;
    rst = r;
    MemGnt = g;
    InstrReady = rdy;
    PCsrc = src;
    target = tgt;
    if (r) begin
      MemRvalid = 1'b0;
      MemRdata = 32'h0;
    end else if (bogus) begin
      MemRvalid = 1'b1;
      MemRdata = 32'hBAD0_BAD0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
      MemRvalid = 1'b1;
      MemRdata = word_of(mem_q[0].addr);
    end else begin
      MemRvalid = 1'b0;
      MemRdata = 32'h0;
    end
  endtask

  initial begin
    rst = 1'b1;
    PC = 32'h0;
    PCsrc = 1'b0;
    MemGnt = 1'b0;
    MemRvalid = 1'b0;
    MemRdata = 32'h0;
    InstrReady = 1'b0;

    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    phase = 1;
    repeat (29) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    pin_pc = 32'h0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    phase = 0;
    PC = 32'h0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    phase = 2;
    repeat (9) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    lat_lo = 1;
    lat_hi = 5;
    for (int i = 0; i < 80; i++) begin
      apply_stimulus(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'b0, 32'h0);
      phase = 3;
    end

    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    phase = 4;
    repeat (11) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    bogus = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    bogus = 1'b0;
    lat_lo = 10;
    lat_hi = 10;
    repeat (3) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    pin_pc = 32'h100;
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    lat_lo = 1;
    lat_hi = 1;
    repeat (25) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    lat_lo = 2;
    lat_hi = 2;
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    phase = 5;
    repeat (9) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    pin_pc = 32'h300;
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
    repeat (20) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    lat_lo = 1;
    lat_hi = 1;
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    phase = 6;
    repeat (7) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    pin_pc = 32'h400;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    PC = 32'h400;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    phase = 7;
    repeat (19) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
